// File: rtl/fft_addr_gen_pkg.sv
// Shared types and helpers for the FFT address generator.
package fft_addr_gen_pkg;

  localparam int unsigned MAX_ADDR_W = 16;

  typedef enum logic [0:0] {
    AGEN_LOAD = 1'b0,
    AGEN_CALC = 1'b1
  } agen_mode_e;

  // Reverse the low 'width' bits of value; upper result bits are zero.
  function automatic logic [MAX_ADDR_W-1:0] bitrev(input logic [MAX_ADDR_W-1:0] value,
                                                   input int unsigned width);
    logic [MAX_ADDR_W-1:0] src;
    logic [MAX_ADDR_W-1:0] res;
    src = value;
    res = '0;
    for (int unsigned i = 0; i < MAX_ADDR_W; i++) begin
      if (i < width) begin
        res = {res[MAX_ADDR_W-2:0], src[0]};
        src = src >> 1;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/fft_addr_gen_if.sv
// Control/status bundle between the FFT control FSM and the address generator.
interface fft_addr_gen_if #(
  parameter int unsigned N_POINTS = 16
);
  localparam int unsigned ADDR_W  = $clog2(N_POINTS);
  localparam int unsigned STAGE_W = $clog2(ADDR_W);

  logic                clear;
  logic                en_cnt_samples;
  logic                wr_mem;
  logic                en_cnt_rd;
  logic [ADDR_W-1:0]   load_addr;
  logic [ADDR_W-1:0]   addr_a;
  logic [ADDR_W-1:0]   addr_b;
  logic [ADDR_W-2:0]   tw_idx;
  logic [STAGE_W-1:0]  stage;
  logic                end_samples;
  logic                end_compute;
  logic                end_algo;

  modport master (
    output clear, en_cnt_samples, wr_mem, en_cnt_rd,
    input  load_addr, addr_a, addr_b, tw_idx, stage, end_samples, end_compute, end_algo
  );

  modport slave (
    input  clear, en_cnt_samples, wr_mem, en_cnt_rd,
    output load_addr, addr_a, addr_b, tw_idx, stage, end_samples, end_compute, end_algo
  );

endinterface

// File: rtl/fft_addr_gen_bitrev.sv
// Parameterised bit-reversal of a W-bit value.
module fft_addr_gen_bitrev
  import fft_addr_gen_pkg::*;
#(
  parameter int unsigned W = 4
) (
  input  logic [W-1:0] value,
  output logic [W-1:0] reversed
);

  assign reversed = W'(bitrev(MAX_ADDR_W'(value), W));

endmodule

// File: rtl/fft_addr_gen.sv
// FFT address/sequencing datapath: bit-reversed load addressing, in-place radix-2
// DIT butterfly addresses, twiddle index and butterfly latency timer.
module fft_addr_gen
  import fft_addr_gen_pkg::*;
#(
  parameter int unsigned N_POINTS = 16,
  parameter int unsigned BFLY_LAT = 2
) (
  input  logic          clk,
  input  logic          rst,
  fft_addr_gen_if.slave bus
);

  localparam int unsigned ADDR_W  = $clog2(N_POINTS);
  localparam int unsigned STAGE_W = $clog2(ADDR_W);
  localparam int unsigned BFLY_W  = ADDR_W - 1;
  localparam int unsigned TMR_W   = $clog2(BFLY_LAT + 1);

  localparam logic [0:0] MODE_LOAD = 1'(AGEN_LOAD);
  localparam logic [0:0] MODE_CALC = 1'(AGEN_CALC);

  localparam logic [ADDR_W-1:0]  LAST_SAMPLE = ADDR_W'(N_POINTS - 1);
  localparam logic [BFLY_W-1:0]  LAST_BFLY   = BFLY_W'(N_POINTS / 2 - 1);
  localparam logic [STAGE_W-1:0] LAST_STAGE  = STAGE_W'(ADDR_W - 1);
  localparam logic [TMR_W-1:0]   TMR_END     = TMR_W'(BFLY_LAT);

  logic [0:0]         mode_q,       mode_d;
  logic [ADDR_W-1:0]  sample_cnt_q, sample_cnt_d;
  logic [STAGE_W-1:0] stage_q,      stage_d;
  logic [BFLY_W-1:0]  bfly_q,       bfly_d;
  logic               running_q,    running_d;
  logic [TMR_W-1:0]   timer_q,      timer_d;
  logic               done_q,       done_d;

  logic               load_done_c;
  logic [ADDR_W-1:0]  load_addr;
  logic [ADDR_W-1:0]  j_ext;
  logic [ADDR_W-1:0]  h_val;
  logic [ADDR_W-1:0]  h_mask;
  logic [ADDR_W-1:0]  addr_a;

  assign load_done_c = (mode_q == MODE_LOAD) && bus.en_cnt_samples && (sample_cnt_q == LAST_SAMPLE);

  always_ff @(posedge clk) begin
    if (rst || bus.clear) begin
      mode_q       <= MODE_LOAD;
      sample_cnt_q <= '0;
      stage_q      <= '0;
      bfly_q       <= '0;
      running_q    <= 1'b0;
      timer_q      <= '0;
      done_q       <= 1'b0;
    end else begin
      mode_q       <= mode_d;
      sample_cnt_q <= sample_cnt_d;
      stage_q      <= stage_d;
      bfly_q       <= bfly_d;
      running_q    <= running_d;
      timer_q      <= timer_d;
      done_q       <= done_d;
    end
  end

  // Next-state: load counting, butterfly timer and stage/butterfly advance.
  always_comb begin
    mode_d       = mode_q;
    sample_cnt_d = sample_cnt_q;
    stage_d      = stage_q;
    bfly_d       = bfly_q;
    running_d    = running_q;
    timer_d      = timer_q;
    done_d       = done_q;

    if (mode_q == MODE_LOAD) begin
      if (bus.en_cnt_samples) sample_cnt_d = sample_cnt_q + ADDR_W'(1);
      if (load_done_c)        mode_d       = MODE_CALC;
    end else if (!done_q) begin
      if (running_q && (timer_q != TMR_END)) timer_d = timer_q + TMR_W'(1);
      if (bus.wr_mem) begin
        running_d = 1'b0;
        if (bfly_q == LAST_BFLY) begin
          if (stage_q == LAST_STAGE) begin
            done_d = 1'b1;
          end else begin
            bfly_d  = '0;
            stage_d = stage_q + STAGE_W'(1);
          end
        end else begin
          bfly_d = bfly_q + BFLY_W'(1);
        end
      end
      // A read pulse in the write cycle restarts the timer for the next butterfly.
      if (bus.en_cnt_rd) begin
        running_d = 1'b1;
        timer_d   = '0;
      end
    end
  end

  // Butterfly addressing: insert a zero at bit 'stage' of j to get the top address.
  always_comb begin
    j_ext  = ADDR_W'(bfly_q);
    h_val  = ADDR_W'(1) << stage_q;
    h_mask = h_val - ADDR_W'(1);
    addr_a = (((j_ext >> stage_q) << 1) << stage_q) | (j_ext & h_mask);
  end

  fft_addr_gen_bitrev #(.W(ADDR_W)) u_bitrev (
    .value    (sample_cnt_q),
    .reversed (load_addr)
  );

  assign bus.load_addr   = load_addr;
  assign bus.addr_a      = addr_a;
  assign bus.addr_b      = addr_a + h_val;
  assign bus.tw_idx      = BFLY_W'((j_ext & h_mask) << (STAGE_W'(ADDR_W - 1) - stage_q));
  assign bus.stage       = stage_q;
  assign bus.end_samples = load_done_c;
  assign bus.end_compute = running_q && (timer_q == TMR_END) && !done_q;
  assign bus.end_algo    = done_q;

endmodule

// File: tb/tb_fft_addr_gen.sv
// Bench for fft_addr_gen (N_POINTS=8, BFLY_LAT=2) driven like the FFT control FSM.
module tb_fft_addr_gen;

  localparam int unsigned N   = 8;
  localparam int unsigned LAT = 2;

  typedef struct packed {
    logic [2:0] addr;
    logic       end_s;
  } ld_vec_t;

  typedef struct packed {
    logic [2:0] a;
    logic [2:0] b;
    logic [1:0] tw;
    logic [1:0] stage;
  } bf_vec_t;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  ld_vec_t ld_tbl [8];
  bf_vec_t bf_tbl [12];
  ld_vec_t lq [$];
  bf_vec_t sb [$];

  always #5 clk = ~clk;

  fft_addr_gen_if #(.N_POINTS(N)) bus ();

  fft_addr_gen #(.N_POINTS(N), .BFLY_LAT(LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // One clock: drive inputs just after the rising edge, return at the falling edge.
  task automatic cyc(input logic r, input logic c, input logic es, input logic wr, input logic rd);
    @(posedge clk);
    #1;
    rst                = r;
    bus.clear          = c;
    bus.en_cnt_samples = es;
    bus.wr_mem         = wr;
    bus.en_cnt_rd      = rd;
    @(negedge clk);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_load_addr"},   32'(bus.load_addr),   32'd0);
    chk({tag, "_addr_a"},      32'(bus.addr_a),      32'd0);
    chk({tag, "_addr_b"},      32'(bus.addr_b),      32'd1);
    chk({tag, "_tw_idx"},      32'(bus.tw_idx),      32'd0);
    chk({tag, "_stage"},       32'(bus.stage),       32'd0);
    chk({tag, "_end_samples"}, 32'(bus.end_samples), 32'd0);
    chk({tag, "_end_compute"}, 32'(bus.end_compute), 32'd0);
    chk({tag, "_end_algo"},    32'(bus.end_algo),    32'd0);
  endtask

  task automatic load_all(input string tag);
    ld_vec_t e;
    for (int i = 0; i < 8; i++) begin
      lq.push_back(ld_tbl[i]);
      cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      e = lq.pop_front();
      chk({tag, "_load_addr"},   32'(bus.load_addr),   32'(e.addr));
      chk({tag, "_end_samples"}, 32'(bus.end_samples), 32'(e.end_s));
    end
  endtask

  // READ_1, READ_2, COMPUTE until end_compute, WRITE.
  task automatic run_bfly(input bf_vec_t e);
    bf_vec_t got;
    int      n;
    sb.push_back(e);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("r1_addr_a", 32'(bus.addr_a), 32'(sb[0].a));
    chk("r1_end_compute", 32'(bus.end_compute), 32'd0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("r2_end_compute", 32'(bus.end_compute), 32'd0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    n = 1;
    while (bus.end_compute !== 1'b1 && n < 8) begin
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      n++;
    end
    chk("compute_latency", 32'(n), 32'(LAT));
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    got = sb.pop_front();
    chk("wr_addr_a", 32'(bus.addr_a), 32'(got.a));
    chk("wr_addr_b", 32'(bus.addr_b), 32'(got.b));
    chk("wr_tw_idx", 32'(bus.tw_idx), 32'(got.tw));
    chk("wr_stage",  32'(bus.stage),  32'(got.stage));
    chk("wr_end_algo", 32'(bus.end_algo), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    ld_tbl[0] = '{3'd0, 1'b0}; ld_tbl[1] = '{3'd4, 1'b0};
    ld_tbl[2] = '{3'd2, 1'b0}; ld_tbl[3] = '{3'd6, 1'b0};
    ld_tbl[4] = '{3'd1, 1'b0}; ld_tbl[5] = '{3'd5, 1'b0};
    ld_tbl[6] = '{3'd3, 1'b0}; ld_tbl[7] = '{3'd7, 1'b1};
    bf_tbl[0]  = '{3'd0, 3'd1, 2'd0, 2'd0}; bf_tbl[1]  = '{3'd2, 3'd3, 2'd0, 2'd0};
    bf_tbl[2]  = '{3'd4, 3'd5, 2'd0, 2'd0}; bf_tbl[3]  = '{3'd6, 3'd7, 2'd0, 2'd0};
    bf_tbl[4]  = '{3'd0, 3'd2, 2'd0, 2'd1}; bf_tbl[5]  = '{3'd1, 3'd3, 2'd2, 2'd1};
    bf_tbl[6]  = '{3'd4, 3'd6, 2'd0, 2'd1}; bf_tbl[7]  = '{3'd5, 3'd7, 2'd2, 2'd1};
    bf_tbl[8]  = '{3'd0, 3'd4, 2'd0, 2'd2}; bf_tbl[9]  = '{3'd1, 3'd5, 2'd1, 2'd2};
    bf_tbl[10] = '{3'd2, 3'd6, 2'd2, 2'd2}; bf_tbl[11] = '{3'd3, 3'd7, 2'd3, 2'd2};

    rst                = 1'b1;
    bus.clear          = 1'b0;
    bus.en_cnt_samples = 1'b0;
    bus.wr_mem         = 1'b0;
    bus.en_cnt_rd      = 1'b0;
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check_reset("por");

    // Full run: load, 12 butterflies, then done.
    load_all("load1");
    for (int k = 0; k < 12; k++) run_bfly(bf_tbl[k]);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("done_end_algo", 32'(bus.end_algo), 32'd1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("done_end_compute", 32'(bus.end_compute), 32'd0);
      chk("done_end_algo_hold", 32'(bus.end_algo), 32'd1);
    end
    chk("done_addr_a", 32'(bus.addr_a), 32'd3);
    chk("done_addr_b", 32'(bus.addr_b), 32'd7);
    chk("done_tw_idx", 32'(bus.tw_idx), 32'd3);
    chk("done_stage",  32'(bus.stage),  32'd2);

    // Clear restarts; then clear together with en_cnt_samples mid-stage-1.
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_reset("clr0");
    load_all("load2");
    for (int k = 0; k < 6; k++) run_bfly(bf_tbl[k]);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("mid_addr_a", 32'(bus.addr_a), 32'd4);
    chk("mid_stage",  32'(bus.stage),  32'd1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_reset("clr1");
    for (int k = 0; k < 3; k++) begin
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("clr_end_compute", 32'(bus.end_compute), 32'd0);
    end
    load_all("load3");

    // Reset during a running butterfly timer.
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("rst_r1_addr_b", 32'(bus.addr_b), 32'd1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_reset("rst");
    for (int k = 0; k < 4; k++) begin
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("rst_end_compute", 32'(bus.end_compute), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
